// File: rtl/snap_capture_ctrl_if.sv
// snap_capture_ctrl_if: stream input and BRAM port A bundle for the snapshot writer
interface snap_capture_ctrl_if #(parameter int AW = 10, parameter int DW = 32);
  logic          trig;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          bram_we;
  logic          bram_en_a;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wr_data;
  modport master (output trig, din, din_valid, input bram_we, bram_en_a, bram_addr, bram_wr_data);
  modport slave  (input trig, din, din_valid, output bram_we, bram_en_a, bram_addr, bram_wr_data);
endinterface

// File: rtl/snap_capture_ctrl.sv
// snap_capture_ctrl: armed/triggered burst writer into a BRAM snapshot buffer.
// Define SNAP_CIRC_EN for pre/post-trigger circular capture.
module snap_capture_ctrl #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int POST_LEN = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  snap_capture_ctrl_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         count,
  output logic [AW-1:0]       trig_addr
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  if (POST_LEN < 1 || POST_LEN > (1 << AW)) begin : g_bad_post_len
    $error("POST_LEN must lie in 1..2^AW");
  end
  state_t        state_q, state_d;
  logic          arm_q;
  logic          arm_pulse, wr, last;
  logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
`ifdef SNAP_CIRC_EN
  localparam logic [AW:0] PL = (AW+1)'(POST_LEN);
  logic          hit;
  logic [AW:0]   post_q, post_d, post_n;
  logic [AW-1:0] tad_q, tad_d;
  always_comb begin
    arm_pulse = arm & ~arm_q;
    hit       = state_q == ARMED && bus.trig;
    wr        = !arm_pulse && bus.din_valid && (state_q == ARMED || state_q == CAPTURE);
    post_n    = hit ? (AW+1)'(1) : post_q + 1'b1;
    last      = post_n == PL;
    post_d    = arm_pulse ? '0 : (wr && (hit || state_q == CAPTURE)) ? post_n : post_q;
    tad_d     = arm_pulse ? '0 : (wr && hit) ? ptr_q : tad_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      post_q <= '0;
      tad_q  <= '0;
    end else begin
      post_q <= post_d;
      tad_q  <= tad_d;
    end
  assign trig_addr = tad_q;
`else
  always_comb begin
    arm_pulse = arm & ~arm_q;
    wr        = !arm_pulse && bus.din_valid && (state_q == CAPTURE || (state_q == ARMED && bus.trig));
    last      = cnt_q == FULL - 1'b1;
  end
  assign trig_addr = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // the write that fills the buffer and the move to DONE land on the same edge
  always_comb begin
    state_d = arm_pulse ? ARMED : state_q;
    if (wr && (state_q == CAPTURE || bus.trig)) state_d = last ? DONE : CAPTURE;
  end
  always_comb begin
    we_d   = wr;
    addr_d = arm_pulse ? '0 : wr ? ptr_q : addr_q;
    data_d = wr ? bus.din : data_q;
    ptr_d  = arm_pulse ? '0 : wr ? ptr_q + 1'b1 : ptr_q;
    cnt_d  = arm_pulse ? '0 : (wr && cnt_q != FULL) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arm_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      arm_q  <= arm;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  assign bus.bram_we      = we_q;
  assign bus.bram_en_a    = we_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_wr_data = data_q;
  assign busy  = state_q == ARMED || state_q == CAPTURE;
  assign done  = state_q == DONE;
  assign count = cnt_q;
endmodule

// File: tb/tb_snap_capture_ctrl.sv
// tb_snap_capture_ctrl: randomized stimulus against a word-counting reference model.
module tb_snap_capture_ctrl;
  localparam int AW = 10, DW = 32, PL = 512, N = 1 << AW;
`ifdef SNAP_CIRC_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  localparam int EXP_W = CIRC ? PL : N;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0;
  logic busy, done;
  logic [AW:0] count;
  logic [AW-1:0] trig_addr;
  snap_capture_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  snap_capture_ctrl #(.AW(AW), .DW(DW), .POST_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .bus(bus.slave),
    .busy(busy), .done(done), .count(count), .trig_addr(trig_addr)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, nwr = 0;
  // reference model: phase 0 idle, 1 armed, 2 capture, 3 done; tot = samples written since arm
  int ph, tot, post, taddr;
  logic m_arm, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, dv;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic mreset();
    ph = 0; tot = 0; post = 0; taddr = 0;
    m_arm = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask
  task automatic model(input logic a, t, v, input logic [DW-1:0] d);
    if (!rst_n) mreset();
    else begin
      logic ap;
      ap = a && !m_arm;
      m_arm = a;
      m_we = 1'b0;
      if (ap) begin
        ph = 1; tot = 0; post = 0; taddr = 0; m_addr = '0;
      end else if (v && (ph == 2 || (ph == 1 && (CIRC || t)))) begin
        if (ph == 1 && t) begin
          if (CIRC) taddr = tot % N;
          ph = 2;
        end
        m_we = 1'b1;
        m_addr = AW'(tot % N);
        m_data = d;
        tot++;
        if (ph == 2) post++;
        if (CIRC ? post == PL : tot == N) ph = 3;
      end
    end
  endtask
  task automatic step(input logic a, t, v, input logic [DW-1:0] d);
    arm = a; bus.trig = t; bus.din_valid = v; bus.din = d;
    model(a, t, v, d);
    @(posedge clk);
    #1;
    if (bus.bram_we) nwr++;
    check("we", bus.bram_we, m_we);
    check("en", bus.bram_en_a, m_we);
    check("addr", bus.bram_addr, m_addr);
    check("data", bus.bram_wr_data, m_data);
    check("count", count, tot < N ? tot : N);
    check("busy", busy, ph == 1 || ph == 2);
    check("done", done, ph == 3);
    check("taddr", trig_addr, taddr);
    @(negedge clk);
  endtask
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    bus.trig = 1'b0; bus.din_valid = 1'b1; bus.din = '0;
    mreset();
    @(negedge clk);
    repeat (3) step(1'b0, rbit(), 1'b1, $urandom);
    rst_n = 1'b1;
    repeat (8) step(1'b0, rbit(), 1'b1, $urandom);
    check("idle_no_write", nwr, 0);
    // linear burst with incrementing data
    dv = 32'h100;
    step(1'b1, 1'b0, 1'b0, '0);
    nwr = 0;
    step(1'b1, 1'b1, 1'b1, dv);
    for (int k = 0; k < 3000 && ph != 3; k++) begin
      dv++;
      step(1'b1, rbit(), 1'b1, dv);
    end
    repeat (3) step(1'b1, rbit(), 1'b1, $urandom);
    check("burst_writes", nwr, EXP_W);
    check("burst_done", done, 1);
    check("burst_count", count, EXP_W);
    // valid gaps
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    nwr = 0;
    step(1'b1, 1'b1, 1'b1, $urandom);
    for (int k = 0; k < 6000 && ph != 3; k++) step(1'b1, rbit(), (k % 2 == 1) || rbit(), $urandom);
    repeat (2) step(1'b1, 1'b0, 1'b1, $urandom);
    check("gap_writes", nwr, EXP_W);
    // re-arm during capture takes priority over trig and valid
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, $urandom);
    for (int k = 0; k < 3000 && tot < 299; k++) step(1'b1, rbit(), rbit(), $urandom);
    step(1'b0, 1'b0, 1'b1, $urandom);
    check("pre_rearm_count", count, 300);
    step(1'b1, 1'b1, 1'b1, $urandom);
    check("rearm_count", count, 0);
    check("rearm_no_write", bus.bram_we, 0);
    check("rearm_busy", busy, 1);
    step(1'b1, 1'b1, 1'b1, $urandom);
    check("restart_we", bus.bram_we, 1);
    check("restart_addr", bus.bram_addr, 0);
    // asynchronous reset mid-capture
    for (int k = 0; k < 3000 && tot < 500; k++) step(1'b1, rbit(), rbit(), $urandom);
    check("pre_reset_count", count, 500);
    #2 rst_n = 1'b0;
    #1;
    check("async_we", bus.bram_we, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_count", count, 0);
    mreset();
    @(negedge clk);
    repeat (3) step(1'b0, rbit(), 1'b1, $urandom);
    rst_n = 1'b1;
    nwr = 0;
    repeat (10) step(1'b0, rbit(), 1'b1, $urandom);
    check("post_reset_no_write", nwr, 0);
    step(1'b1, 1'b0, 1'b1, $urandom);
    for (int k = 0; k < 6000 && ph != 3; k++) step(1'b1, rbit(), rbit(), $urandom);
    check("final_done", done, 1);
`ifdef SNAP_CIRC_EN
    begin
      logic [AW-1:0] last_addr;
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      repeat (1500) step(1'b1, 1'b0, 1'b1, $urandom);
      check("circ_pre_count", count, N);
      step(1'b1, 1'b1, 1'b1, $urandom);
      check("circ_trig_addr", trig_addr, 1500 % N);
      last_addr = bus.bram_addr;
      nwr = 0;
      for (int k = 0; k < 600 && ph != 3; k++) begin
        step(1'b1, rbit(), 1'b1, $urandom);
        if (bus.bram_we) last_addr = bus.bram_addr;
      end
      check("circ_post_writes", nwr, PL - 1);
      check("circ_last_addr", last_addr, (1500 % N + PL - 1) % N);
      check("circ_done", done, 1);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
